uart_dram_cmd_ctrl: RTL and testbench
=====================================

UART_DRAM_CMD_CTRL -- requirements
Module: uart_dram_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width; multiple of 8.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width; multiple of 8.
REQ-003 SHALL have parameter WTO, default 16'hFFFF, cycles allowed for a read response before timeout.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 nrst  in  1  reset, asynchronous, active-low.
REQ-006 rx_data  in  8  command byte from the serial receive stream.
REQ-007 rx_valid  in  1  rx_data valid.
REQ-008 rx_ready  out  1  byte accepted when rx_valid && rx_ready.
REQ-009 tx_data  out  8  response byte to the serial transmit stream.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  byte taken when tx_valid && tx_ready.
REQ-012 mem_valid / mem_ready  out / in  1 / 1  memory request handshake.
REQ-013 mem_we  out  1  1 = write, 0 = read.
REQ-014 mem_addr / mem_wdata  out  ADDR_W / DATA_W  request address and write data.
REQ-015 mem_rdata / mem_rvalid  in  DATA_W / 1  read data, one-cycle pulse, never back-pressured.
REQ-016 busy  out  1  high whenever state != IDLE.

Function
REQ-017 Protocol: opcode byte, then ADDR_W/8 address bytes, then (writes only) DATA_W/8 data bytes; all multi-byte fields little-endian (first byte = bits [7:0]).
REQ-018 Opcodes: 0x57 write, 0x52 read; any other opcode -> transmit single NAK 0x15 and return to IDLE with no memory access.
REQ-019 States: IDLE, ADDR, WDATA, MREQ, MWAIT, SEND, ACK.
REQ-020 IDLE --valid opcode--> ADDR; ADDR --last addr byte--> WDATA (write) or MREQ (read); WDATA --last data byte--> MREQ.
REQ-021 rx_ready SHALL be 1 only in IDLE, ADDR, WDATA; byte counter resets to 0 on each state entry.
REQ-022 MREQ: mem_valid=1 with mem_addr/mem_wdata/mem_we stable until mem_ready; on handshake go to ACK (write) or MWAIT (read).
REQ-023 ACK: tx_data=0x06, tx_valid=1 until tx_ready, then IDLE.
REQ-024 MWAIT: capture mem_rdata on mem_rvalid, go to SEND; mem_rvalid in any other state is ignored.
REQ-025 MWAIT timeout: after WTO cycles with no mem_rvalid, transmit NAK 0x15, return to IDLE.
REQ-026 SEND: emit DATA_W/8 bytes LSB first, one per tx handshake, then IDLE; tx_valid held, tx_data stable while tx_ready=0.
REQ-027 Minimum latency: mem_valid asserts the cycle after the final command byte handshake; first response byte tx_valid the cycle after mem_rvalid (read) or mem handshake (write).
REQ-028 No new command accepted until the response completes (no pipelining).

Reset
REQ-029 nrst low SHALL asynchronously force IDLE, counters 0, rx_ready=0 during reset, tx_valid=0, mem_valid=0, mem_we=0, mem_addr/mem_wdata/tx_data=0, busy=0.
REQ-030 Reset mid-command SHALL discard partial fields and in-flight read; a mem_rvalid after reset release in IDLE is ignored.

Structure
REQ-031 Package uart_cmd_pkg SHALL hold opcode constants (OP_WR, OP_RD), ACK/NAK bytes, and the state enum.
REQ-032 Single module; no sub-module; byte counters sized by $clog2 of the larger byte count.

Verification
REQ-033 Write: bytes 57 10 00 00 00 EF BE AD DE -> one request mem_we=1 addr 0x10 wdata 0xDEADBEEF, then tx 06.
REQ-034 Read: 52 10 00 00 00, mem_rdata 0xDEADBEEF after 3 cycles -> tx EF BE AD DE in order.
REQ-035 Bad opcode 0x41 -> tx 15, no mem_valid, following valid command processed normally.
REQ-036 Back-pressure: mem_ready low 5 cycles and tx_ready toggling -> request fields and tx_data stable, no byte lost or duplicated.
REQ-037 Read with no mem_rvalid for WTO cycles -> tx 15, busy drops; nrst pulse after 2 address bytes -> IDLE, next command correct.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants for the UART-to-DRAM command controller: protocol opcodes,
// the single-byte ACK/NAK responses and the controller state enum.
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] OP_WR    = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD    = 8'h52;  // 'R'
    localparam logic [7:0] BYTE_ACK = 8'h06;
    localparam logic [7:0] BYTE_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MREQ,
        MWAIT,
        SEND,
        ACK
    } state_t;

endpackage

// File: rtl/uart_dram_cmd_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_dram_cmd_ctrl_if
// Bundles the three handshake channels of the command controller:
//   rx_*  : command byte stream in (valid/ready)
//   tx_*  : response byte stream out (valid/ready)
//   mem_* : memory request (valid/ready) plus unthrottled read-data pulse
// modport master : the controller side
// modport slave  : the environment side (serial link + memory)
// ----------------------------------------------------------------------------
interface uart_dram_cmd_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;

    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_rvalid
    );

endinterface

// File: rtl/uart_dram_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_dram_cmd_ctrl
// Parses a byte-serial command stream into single memory requests and returns
// the response bytes.
//   Command : opcode, ADDR_W/8 address bytes, (write only) DATA_W/8 data bytes,
//             all fields little-endian.
//   Write   : one memory write, then ACK (0x06).
//   Read    : one memory read, then DATA_W/8 data bytes LSB first; NAK (0x15)
//             if no read data arrives within WTO cycles.
//   Other opcodes are answered with NAK and cause no memory access.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : rx / tx / memory channels (master side)
//   busy      : high whenever the controller is not idle
// ----------------------------------------------------------------------------
module uart_dram_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter int unsigned WTO    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  nrst,
    uart_dram_cmd_ctrl_if.master  bus,
    output logic                  busy
);

    localparam int unsigned AB    = ADDR_W / 8;
    localparam int unsigned DB    = DATA_W / 8;
    localparam int unsigned MAXB  = (AB > DB) ? AB : DB;
    localparam int unsigned CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int unsigned TMR_W = (WTO > 1) ? $clog2(WTO) : 1;

    state_t             state_q, state_d;
    logic               run_q;      // keeps rx_ready low until reset is released
    logic [CNT_W-1:0]   cnt_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               we_q;
    logic [7:0]         resp_q;     // byte sent from the ACK state (ACK or NAK)
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;

    logic rx_fire, tx_fire, op_ok, last_addr, last_data, timeout;

    assign rx_fire   = bus.rx_valid && bus.rx_ready;
    assign tx_fire   = bus.tx_valid && bus.tx_ready;
    assign op_ok     = (bus.rx_data == OP_WR) || (bus.rx_data == OP_RD);
    assign last_addr = (cnt_q == CNT_W'(AB - 1));
    assign last_data = (cnt_q == CNT_W'(DB - 1));
    assign timeout   = (tmr_q == TMR_W'(WTO - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    state_d = op_ok ? ADDR : ACK;
                end
            end
            ADDR: begin
                if (rx_fire && last_addr) begin
                    state_d = we_q ? WDATA : MREQ;
                end
            end
            WDATA: begin
                if (rx_fire && last_data) begin
                    state_d = MREQ;
                end
            end
            MREQ: begin
                if (bus.mem_ready) begin
                    state_d = we_q ? ACK : MWAIT;
                end
            end
            MWAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = SEND;
                end else if (timeout) begin
                    state_d = ACK;
                end
            end
            SEND: begin
                if (tx_fire && last_data) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (tx_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and captured command/response fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            we_q    <= 1'b0;
            resp_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            run_q <= 1'b1;

            // Byte counter restarts on every state change so each field
            // (and the read response) is indexed from byte 0.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if ((rx_fire && (state_q == ADDR || state_q == WDATA)) ||
                         (tx_fire && state_q == SEND)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == MWAIT && state_d == MWAIT) begin
                tmr_q <= tmr_q + 1'b1;
            end else begin
                tmr_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_fire) begin
                        we_q   <= (bus.rx_data == OP_WR);
                        resp_q <= op_ok ? BYTE_ACK : BYTE_NAK;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        addr_q[8*int'(cnt_q) +: 8] <= bus.rx_data;
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        wdata_q[8*int'(cnt_q) +: 8] <= bus.rx_data;
                    end
                end
                MWAIT: begin
                    if (bus.mem_rvalid) begin
                        rdata_q <= bus.mem_rdata;
                    end else if (timeout) begin
                        resp_q <= BYTE_NAK;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.rx_ready  = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE, ADDR, WDATA: begin
                bus.rx_ready = run_q;
            end
            MREQ: begin
                bus.mem_valid = 1'b1;
                bus.mem_we    = we_q;
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = rdata_q[8*int'(cnt_q) +: 8];
            end
            ACK: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = resp_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_dram_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_dram_cmd_ctrl
// Directed bench for uart_dram_cmd_ctrl: write, read, bad opcode, memory and
// tx back-pressure, read timeout and reset in the middle of a command.
// ----------------------------------------------------------------------------
module tb_uart_dram_cmd_ctrl;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int unsigned WTO    = 20;

    logic clk;
    logic nrst;
    logic busy;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_mem   = 0;

    uart_dram_cmd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    uart_dram_cmd_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WTO    (WTO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory request handshakes
    always @(posedge clk) begin
        if (bus.mem_valid && bus.mem_ready) n_mem++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            tick();
            n++;
        end
        check("rx_ready", bus.rx_ready, 1);
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp, input bit stall);
        int unsigned n = 0;
        while (!bus.tx_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.tx_valid, 1);
        check({tag, "_data"}, bus.tx_data, exp);
        if (stall) begin
            bus.tx_ready = 1'b0;
            tick();
            check({tag, "_hold_valid"}, bus.tx_valid, 1);
            check({tag, "_hold_data"}, bus.tx_data, exp);
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int unsigned stall);
        int unsigned m0 = n_mem;
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
        // mem_valid must be up the cycle after the last command byte
        check("wr_mem_valid", bus.mem_valid, 1);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, addr);
        check("wr_mem_wdata", bus.mem_wdata, data);
        check("wr_rx_ready_low", bus.rx_ready, 0);
        for (int i = 0; i < int'(stall); i++) begin
            tick();
            check("wr_stall_valid", bus.mem_valid, 1);
            check("wr_stall_we", bus.mem_we, 1);
            check("wr_stall_addr", bus.mem_addr, addr);
            check("wr_stall_wdata", bus.mem_wdata, data);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("wr_mem_valid_drop", bus.mem_valid, 0);
        check("wr_ack_valid_now", bus.tx_valid, 1);
        recv_byte("wr_ack", 8'h06, stall != 0);
        check("wr_busy_end", busy, 0);
        check("wr_mem_count", n_mem - m0, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int unsigned stall);
        int unsigned m0 = n_mem;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        check("rd_mem_valid", bus.mem_valid, 1);
        check("rd_mem_we", bus.mem_we, 0);
        check("rd_mem_addr", bus.mem_addr, addr);
        for (int i = 0; i < int'(stall); i++) begin
            tick();
            check("rd_stall_valid", bus.mem_valid, 1);
            check("rd_stall_addr", bus.mem_addr, addr);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("rd_mem_valid_drop", bus.mem_valid, 0);
        check("rd_wait_busy", busy, 1);
        repeat (3) tick();
        check("rd_wait_no_tx", bus.tx_valid, 0);
        bus.mem_rdata  = data;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        check("rd_tx_valid_now", bus.tx_valid, 1);
        for (int i = 0; i < 4; i++) recv_byte("rd_byte", data[8*i +: 8], (i % 2) == 0);
        check("rd_busy_end", busy, 0);
        check("rd_tx_idle", bus.tx_valid, 0);
        check("rd_mem_count", n_mem - m0, 1);
    endtask

    initial begin
        int unsigned n;
        int unsigned m0;

        nrst           = 1'b0;
        bus.rx_data    = '0;
        bus.rx_valid   = 1'b0;
        bus.tx_ready   = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        nrst = 1'b1;
        tick();
        check("idle_rx_ready", bus.rx_ready, 1);

        // Write with 5-cycle memory stall and tx back-pressure
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 5);

        // Read, data 3 cycles after handshake, toggling tx_ready
        do_read(32'h0000_0010, 32'hDEAD_BEEF, 0);

        // Stray read data while idle is ignored
        bus.mem_rdata  = 32'h1234_5678;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        check("idle_rvalid_tx", bus.tx_valid, 0);
        check("idle_rvalid_busy", busy, 0);

        // Bad opcode -> NAK, no memory access, next command fine
        m0 = n_mem;
        send_byte(8'h41);
        check("bad_mem_valid", bus.mem_valid, 0);
        check("bad_rx_ready", bus.rx_ready, 0);
        recv_byte("bad_nak", 8'h15, 1'b1);
        check("bad_busy_end", busy, 0);
        check("bad_mem_count", n_mem - m0, 0);
        do_write(32'h1234_5678, 32'hCAFE_F00D, 2);

        // Read timeout -> NAK exactly WTO cycles after the handshake
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h44 : 8'h00);
        check("to_mem_addr", bus.mem_addr, 32'h44);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n = 0;
        while (!bus.tx_valid && n < 200) begin
            tick();
            n++;
        end
        check("to_cycles", n, WTO);
        recv_byte("to_nak", 8'h15, 1'b0);
        check("to_busy_end", busy, 0);
        // Late data after timeout is ignored
        bus.mem_rdata  = 32'hAAAA_5555;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        check("to_late_tx", bus.tx_valid, 0);

        // Reset after two address bytes discards the partial command
        send_byte(8'h52);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check("mid_busy", busy, 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx_ready", bus.rx_ready, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        tick();
        nrst = 1'b1;
        tick();
        do_read(32'h0000_0020, 32'h0102_0304, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "time limit");
    end

endmodule
